// File: rtl/led_shift_sequencer_pkg.sv
// Shared types and constants for the LED timing blocks.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } seq_state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CHAIN = 4;
  localparam int DEF_DIV   = 1;

  // Counter width for a 0..n-1 counter, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_shift_sequencer_if.sv
// Frame handshake between the frame source (master) and the sequencer (slave).
interface led_shift_sequencer_if
  import led_ctrl_pkg::*;
#(
  parameter int N = DEF_WIDTH * DEF_CHAIN
);
  logic [N-1:0] frame_data;
  logic         frame_valid;
  logic         frame_ready;

  modport master (output frame_data, frame_valid, input frame_ready);
  modport slave  (input frame_data, frame_valid, output frame_ready);
endinterface

// File: rtl/led_shift_sequencer_strobe_div.sv
// Clock divider: counts 0..DIV-1 while run is high and flags the wrap cycle.
// strobe is registered and high during the cycle whose count is DIV-1;
// strobe_nxt is its next value so callers can register aligned outputs.
module strobe_div
  import led_ctrl_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic strobe,
  output logic strobe_nxt
);
  localparam int CW = cnt_w(DIV);
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt, cnt_nxt;

  // Next count: clear wins; holds when not running; wraps at DIV-1.
  always_comb begin
    cnt_nxt = cnt;
    if (clear)    cnt_nxt = '0;
    else if (run) cnt_nxt = (cnt == TERM) ? '0 : cnt + 1'b1;
    strobe_nxt = run && (cnt_nxt == TERM);
  end

  // Counter and strobe registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      strobe <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      strobe <= strobe_nxt;
    end
  end
endmodule

// File: rtl/led_shift_sequencer.sv
// Serialises one parallel frame MSB-first into an enable-low shift-register
// chain, then pulses latch. Outputs are registered from next-state values so
// each one lines up with the internal state of the cycle it is visible in.
// Optional: define LED_SEQ_BLANK_EN to add the blank output.
module led_shift_sequencer
  import led_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHAIN = DEF_CHAIN,
  parameter int DIV   = DEF_DIV
) (
  input  logic                  clk,
  input  logic                  reset,
  led_shift_sequencer_if.slave  frm,
  output logic                  sdata,
  output logic                  sen_n,
  output logic                  latch,
`ifdef LED_SEQ_BLANK_EN
  output logic                  blank,
`endif
  output logic                  busy
);
  localparam int N  = WIDTH * CHAIN;
  localparam int BW = cnt_w(N);
  localparam logic [BW-1:0] LAST = BW'(N - 1);

  seq_state_e    state, state_nxt;
  logic [N-1:0]  shadow, shadow_nxt;
  logic [BW-1:0] bitc, bitc_nxt;
  logic          ready_q, take, run, stb, stb_nxt;
  logic          ready_d, sdata_d, sen_n_d, latch_d, busy_d;

  assign take           = frm.frame_valid && ready_q;
  assign run            = (state_nxt == SHIFT);
  assign frm.frame_ready = ready_q;

  strobe_div #(.DIV(DIV)) u_div (
    .clk        (clk),
    .reset      (reset),
    .clear      (take),
    .run        (run),
    .strobe     (stb),
    .strobe_nxt (stb_nxt)
  );

  // State, shadow and bit counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      shadow <= '0;
      bitc   <= '0;
    end else begin
      state  <= state_nxt;
      shadow <= shadow_nxt;
      bitc   <= bitc_nxt;
    end
  end

  // Next state: leave SHIFT on the strobe of the last bit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = SHIFT;
      SHIFT:   if (stb && bitc == LAST) state_nxt = LATCH;
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on transfer, shift and count on each strobe.
  always_comb begin
    shadow_nxt = shadow;
    bitc_nxt   = bitc;
    if (take) begin
      shadow_nxt = frm.frame_data;
      bitc_nxt   = '0;
    end else if (state == SHIFT && stb) begin
      shadow_nxt = shadow << 1;
      if (bitc != LAST) bitc_nxt = bitc + 1'b1;
    end
  end

  // Output decode from next-state values; sdata holds between strobes.
  always_comb begin
    ready_d = (state_nxt == IDLE);
    busy_d  = (state_nxt != IDLE);
    latch_d = (state_nxt == LATCH);
    sen_n_d = !stb_nxt;
    sdata_d = stb_nxt ? shadow_nxt[N-1] : sdata;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ready_q <= 1'b1;
      sdata   <= 1'b0;
      sen_n   <= 1'b1;
      latch   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ready_q <= ready_d;
      sdata   <= sdata_d;
      sen_n   <= sen_n_d;
      latch   <= latch_d;
      busy    <= busy_d;
    end
  end

`ifdef LED_SEQ_BLANK_EN
  // Blank from the first shift cycle until the latch pulse has been issued.
  always_ff @(posedge clk) begin
    if (!reset)              blank <= 1'b1;
    else if (take)           blank <= 1'b1;
    else if (state == LATCH) blank <= 1'b0;
  end
`endif
endmodule
